// File: rtl/lock_freq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_freq_pkg
// Brief    : Shared state encoding and default timing constants for the
//            frequency-coded phase-lock transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package lock_freq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // 10 kHz and 5 kHz half-periods at 20 MHz, 10 ms heartbeat timeout
    localparam int C_LOCK_HALF_DEF    = 1000;
    localparam int C_NONLOCK_HALF_DEF = 2000;
    localparam int C_CNT_W_DEF        = 16;
    localparam int C_WDT_CYCLES_DEF   = 200000;

endpackage
`default_nettype wire

// File: rtl/lock_tx_wdt.sv
`default_nettype none
// ============================================================================
// Module   : lock_tx_wdt
// Brief    : Heartbeat watchdog; any heartbeat edge restarts the timeout,
//            expiry raises o_wdt_trip until the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module lock_tx_wdt #(
    parameter int WDT_CYCLES = 200000
) (
    input  logic i_clk_20M,
    input  logic i_reset_n,
    input  logic i_heartbeat,
    output logic o_wdt_trip
);

    localparam int C_W = $clog2(WDT_CYCLES + 1);
    localparam logic [C_W-1:0] C_LIMIT   = C_W'(WDT_CYCLES);
    localparam logic [C_W-1:0] C_LIMIT_M1 = C_W'(WDT_CYCLES - 1);

    logic           hb_q;
    logic           hb_d;
    logic [C_W-1:0] cnt_q;
    logic [C_W-1:0] cnt_d;
    logic           trip_q;
    logic           trip_d;
    logic           w_hb_edge;

    assign w_hb_edge = i_heartbeat ^ hb_q;

    // Counter saturates at the limit so the trip holds without wrapping
    always_comb begin
        hb_d   = i_heartbeat;
        cnt_d  = cnt_q;
        trip_d = trip_q;
        if (w_hb_edge) begin
            cnt_d  = '0;
            trip_d = 1'b0;
        end else if (cnt_q != C_LIMIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LIMIT_M1) begin
                trip_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_20M or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hb_q   <= 1'b0;
            cnt_q  <= '0;
            trip_q <= 1'b0;
        end else begin
            hb_q   <= hb_d;
            cnt_q  <= cnt_d;
            trip_q <= trip_d;
        end
    end

    assign o_wdt_trip = trip_q;

endmodule
`default_nettype wire

// File: rtl/lock_freq_tx.sv
`default_nettype none
// ============================================================================
// Module   : lock_freq_tx
// Brief    : Frequency-coded phase-lock line transmitter (LOCK / NONLOCK
//            square wave). Define LOCK_TX_FAILSAFE_EN to add the heartbeat
//            watchdog that forces the LOCK code.
// Revision : 1.0 - initial release
// ============================================================================
module lock_freq_tx
    import lock_freq_pkg::*;
#(
    parameter int LOCK_HALF    = C_LOCK_HALF_DEF,
    parameter int NONLOCK_HALF = C_NONLOCK_HALF_DEF,
    parameter int CNT_W        = C_CNT_W_DEF,
    parameter int WDT_CYCLES   = C_WDT_CYCLES_DEF
) (
    input  logic i_clk_20M,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_lock_req,
    input  logic i_brk_test,
    input  logic i_heartbeat,
    output logic o_tx,
    output logic o_tx_is_lock,
    output logic o_period_stb,
    output logic o_wdt_trip
);

    localparam logic [CNT_W-1:0] C_LOCK_M1    = CNT_W'(LOCK_HALF - 1);
    localparam logic [CNT_W-1:0] C_NONLOCK_M1 = CNT_W'(NONLOCK_HALF - 1);

    generate
        if (LOCK_HALF < 2 || NONLOCK_HALF < 2) begin : g_bad_half
            $error("lock_freq_tx: LOCK_HALF and NONLOCK_HALF must be >= 2");
        end
    endgenerate

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mode_q;
    logic             mode_d;
    logic             tx_q;
    logic             tx_d;
    logic             stb_q;
    logic             stb_d;
    logic             w_wdt_trip;
    logic             w_eff_lock;
    logic [CNT_W-1:0] w_half_m1;

`ifdef LOCK_TX_FAILSAFE_EN
    lock_tx_wdt #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .i_clk_20M   (i_clk_20M),
        .i_reset_n   (i_reset_n),
        .i_heartbeat (i_heartbeat),
        .o_wdt_trip  (w_wdt_trip)
    );
    assign w_eff_lock = i_lock_req | w_wdt_trip;
`else
    logic unused_wdt;
    assign unused_wdt = i_heartbeat | (WDT_CYCLES < 1);
    assign w_wdt_trip = 1'b0;
    assign w_eff_lock = i_lock_req;
`endif

    // Half-period follows the latched mode so both phases of a period match
    assign w_half_m1 = mode_q ? C_LOCK_M1 : C_NONLOCK_M1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        stb_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    mode_d  = w_eff_lock;
                end
            end
            ST_HIGH: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == w_half_m1) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOW: begin
                // Disable wins over a coincident boundary: no strobe
                if (!i_enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == w_half_m1) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    mode_d  = w_eff_lock;
                    stb_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        tx_d = (state_d == ST_HIGH) && !i_brk_test;
    end

    always_ff @(posedge i_clk_20M or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b1;
            tx_q    <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            stb_q   <= stb_d;
        end
    end

    assign o_tx         = tx_q;
    assign o_tx_is_lock = mode_q;
    assign o_period_stb = stb_q;
    assign o_wdt_trip   = w_wdt_trip;

endmodule
`default_nettype wire

// File: tb/tb_lock_freq_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_freq_tx
// Brief    : Directed self-checking bench for lock_freq_tx (LOCK_HALF=4,
//            NONLOCK_HALF=8, WDT_CYCLES=50).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_freq_tx;

    localparam int C_LH  = 4;
    localparam int C_NH  = 8;
    localparam int C_WDT = 50;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic en     = 1'b0;
    logic lock   = 1'b1;
    logic brk    = 1'b0;
    logic hb     = 1'b0;
    logic hb_run = 1'b1;
    logic w_tx;
    logic w_is_lock;
    logic w_stb;
    logic w_trip;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lock_freq_tx #(
        .LOCK_HALF    (C_LH),
        .NONLOCK_HALF (C_NH),
        .CNT_W        (16),
        .WDT_CYCLES   (C_WDT)
    ) dut (
        .i_clk_20M    (clk),
        .i_reset_n    (rst_n),
        .i_enable     (en),
        .i_lock_req   (lock),
        .i_brk_test   (brk),
        .i_heartbeat  (hb),
        .o_tx         (w_tx),
        .o_tx_is_lock (w_is_lock),
        .o_period_stb (w_stb),
        .o_wdt_trip   (w_trip)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (hb_run) hb = ~hb;
    endtask

    task automatic expect_cyc(input string tag, input logic etx, input logic estb, input logic elock);
        tick();
        check({tag, "_tx"}, 32'(w_tx), 32'(etx));
        check({tag, "_stb"}, 32'(w_stb), 32'(estb));
        check({tag, "_lock"}, 32'(w_is_lock), 32'(elock));
    endtask

    int n;

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_tx", 32'(w_tx), 32'd0);
        check("rst_lock", 32'(w_is_lock), 32'd1);
        check("rst_stb", 32'(w_stb), 32'd0);
        check("rst_trip", 32'(w_trip), 32'd0);
        rst_n = 1'b1;
        expect_cyc("idle", 1'b0, 1'b0, 1'b1);

        // LOCK code: 4 high / 4 low, strobe at each period start
        en = 1'b1;
        for (int k = 0; k < 16; k++)
            expect_cyc("lockA", (k % 8) < 4, (k % 8 == 0) && (k != 0), 1'b1);

        // Lock request drops mid-HIGH: current period finishes as LOCK
        for (int k = 16; k < 19; k++)
            expect_cyc("chgB", 1'b1, k == 16, 1'b1);
        lock = 1'b0;
        for (int k = 19; k < 24; k++)
            expect_cyc("chgB", k < 20, 1'b0, 1'b1);
        for (int k = 24; k < 28; k++)
            expect_cyc("nlB", 1'b1, k == 24, 1'b0);

        // Async reset mid-HIGH, checked between clock edges
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx", 32'(w_tx), 32'd0);
        check("arst_lock", 32'(w_is_lock), 32'd1);
        check("arst_stb", 32'(w_stb), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        // Enabled out of reset: HIGH on the first edge, NONLOCK 8/8
        for (int j = 0; j < 16; j++)
            expect_cyc("nlE", j < 8, 1'b0, 1'b0);
        // Disable exactly on the LOW->HIGH boundary cycle
        en = 1'b0;
        expect_cyc("disC", 1'b0, 1'b0, 1'b0);
        expect_cyc("disC2", 1'b0, 1'b0, 1'b0);

        // Restart as LOCK, then break test for 20 cycles
        en   = 1'b1;
        lock = 1'b1;
        for (int j = 0; j < 6; j++)
            expect_cyc("preD", (j % 8) < 4, (j % 8 == 0) && (j != 0), 1'b1);
        brk = 1'b1;
        for (int j = 6; j < 26; j++)
            expect_cyc("brkD", 1'b0, (j % 8) == 0, 1'b1);
        brk = 1'b0;
        for (int j = 26; j < 34; j++)
            expect_cyc("postD", (j % 8) < 4, (j % 8) == 0, 1'b1);

`ifdef LOCK_TX_FAILSAFE_EN
        // Heartbeat stops with NONLOCK requested: trip, then forced LOCK
        lock   = 1'b0;
        hb_run = 1'b0;
        n = 0;
        while (!w_trip && n < 100) begin
            tick();
            n++;
        end
        check("wdt_trip", 32'(w_trip), 32'd1);
        check("wdt_trip_cyc", 32'(n), 32'(C_WDT + 1));
        n = 0;
        while (!w_is_lock && n < 4 * C_NH) begin
            tick();
            n++;
        end
        for (int j = 0; j < 4 * C_NH; j++) begin
            if (!w_stb) tick();
        end
        check("wdt_forced_lock", 32'(w_is_lock), 32'd1);
        hb = ~hb;
        tick();
        check("wdt_clear", 32'(w_trip), 32'd0);
        n = 0;
        while (w_is_lock && n < 4 * C_NH) begin
            tick();
            n++;
        end
        check("wdt_nl_resume", 32'(w_is_lock), 32'd0);
`else
        hb_run = 1'b0;
        lock   = 1'b0;
        repeat (C_WDT + 10) tick();
        check("no_wdt_trip", 32'(w_trip), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
